// File: rtl/rob_nw_pkg.sv
// Shared widths, ROB entry payloads and branch-resolution helper for rob_nw.
package rob_nw_pkg;

  localparam int unsigned ROB_LENGTH       = 8;
  localparam int unsigned INSTR_MEM_IDX_W  = 8;
  localparam int unsigned ARCH_REG_IDX_W   = 5;
  localparam int unsigned PHYS_REG_IDX_W   = 6;
  localparam int unsigned INT_DATA_W       = 32;
  localparam int unsigned ROB_COMMIT_W_MAX = 4;
  localparam int unsigned COMMIT_CNT_W     = $clog2(ROB_COMMIT_W_MAX + 1);

  typedef struct packed {
    logic                       valid;
    logic                       done;
    logic [INSTR_MEM_IDX_W-1:0] pc;
    logic [ARCH_REG_IDX_W-1:0]  logical_rd;
    logic [PHYS_REG_IDX_W-1:0]  phys_rd;
    logic [INT_DATA_W-1:0]      result;
    logic                       is_store;
    logic                       is_load;
    logic                       is_branch;
    logic                       pred_taken;
    logic [INSTR_MEM_IDX_W-1:0] pred_target;
  } rob_entry_t;

  // actual_target holds the fetch restart index (pc+1 for a not-taken resolution)
  typedef struct packed {
    rob_entry_t                 base;
    logic                       mispred;
    logic [INSTR_MEM_IDX_W-1:0] actual_target;
  } rob_nw_entry_t;

  function automatic logic branch_mispred(
    input logic                       pred_taken,
    input logic [INSTR_MEM_IDX_W-1:0] pred_target,
    input logic                       act_taken,
    input logic [INSTR_MEM_IDX_W-1:0] act_target
  );
    return (act_taken != pred_taken) || (act_taken && (act_target != pred_target));
  endfunction

endpackage

// File: rtl/rob_commit_sel.sv
// Prefix selection of retiring slots: stops at the first not-done slot or after a mispredicted one.
module rob_commit_sel
  import rob_nw_pkg::*;
#(
  parameter int unsigned COMMIT_W = 2
) (
  input  logic                    stall,
  input  logic [COMMIT_W-1:0]     in_range,
  input  logic [COMMIT_W-1:0]     done,
  input  logic [COMMIT_W-1:0]     mispred,
  output logic [COMMIT_W-1:0]     commit_valid,
  output logic [COMMIT_CNT_W-1:0] commit_cnt
);

  logic chain_ok;

  always_comb begin
    commit_valid = '0;
    commit_cnt   = '0;
    chain_ok     = !stall;
    for (int k = 0; k < COMMIT_W; k++) begin
      chain_ok        = chain_ok && in_range[k] && done[k];
      commit_valid[k] = chain_ok;
      commit_cnt      = commit_cnt + COMMIT_CNT_W'(chain_ok);
      chain_ok        = chain_ok && !mispred[k];
    end
  end

endmodule

// File: rtl/rob_nw.sv
// In-order-commit reorder buffer: 1 dispatch, WB_PORTS writebacks, up to COMMIT_W retires per cycle.
// Optional ROB_PERF_CNT_EN adds perf_commits / perf_flushes / perf_full_cycles counters.
module rob_nw
  import rob_nw_pkg::*;
#(
  parameter int unsigned DEPTH     = ROB_LENGTH,
  parameter int unsigned COMMIT_W  = 2,
  parameter int unsigned WB_PORTS  = 2,
  localparam int unsigned ROB_IDX_W = $clog2(DEPTH)
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       disp_valid,
  output logic                                       disp_ready,
  input  logic [INSTR_MEM_IDX_W-1:0]                 disp_pc,
  input  logic [ARCH_REG_IDX_W-1:0]                  disp_logical_rd,
  input  logic [PHYS_REG_IDX_W-1:0]                  disp_phys_rd,
  input  logic                                       disp_is_store,
  input  logic                                       disp_is_load,
  input  logic                                       disp_is_branch,
  input  logic                                       disp_pred_taken,
  input  logic [INSTR_MEM_IDX_W-1:0]                 disp_pred_target,
  output logic [ROB_IDX_W-1:0]                       disp_rob_idx,
  input  logic [WB_PORTS-1:0]                        wb_valid,
  input  logic [WB_PORTS-1:0][ROB_IDX_W-1:0]         wb_rob_idx,
  input  logic [WB_PORTS-1:0][INT_DATA_W-1:0]        wb_result,
  input  logic [WB_PORTS-1:0]                        wb_actual_taken,
  input  logic [WB_PORTS-1:0][INSTR_MEM_IDX_W-1:0]   wb_actual_target,
  input  logic                                       commit_stall,
  output logic [COMMIT_W-1:0]                        commit_valid,
  output logic [COMMIT_W-1:0][INSTR_MEM_IDX_W-1:0]   commit_pc,
  output logic [COMMIT_W-1:0][ARCH_REG_IDX_W-1:0]    commit_logical_rd,
  output logic [COMMIT_W-1:0][PHYS_REG_IDX_W-1:0]    commit_phys_rd,
  output logic [COMMIT_W-1:0][INT_DATA_W-1:0]        commit_result,
  output logic [COMMIT_W-1:0]                        commit_is_store,
  output logic [COMMIT_W-1:0]                        commit_is_load,
  output logic                                       flush,
  output logic [INSTR_MEM_IDX_W-1:0]                 redirect_pc,
  output logic                                       empty
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]                                perf_commits,
  output logic [31:0]                                perf_flushes,
  output logic [31:0]                                perf_full_cycles
`endif
);

  localparam int unsigned CNT_W = ROB_IDX_W + 1;

  rob_nw_entry_t                       entries [DEPTH];
  rob_nw_entry_t                       disp_entry;
  logic [ROB_IDX_W-1:0]                head;
  logic [ROB_IDX_W-1:0]                tail;
  logic [CNT_W-1:0]                    count;
  logic [COMMIT_W-1:0][ROB_IDX_W-1:0]  slot_idx;
  logic [COMMIT_W-1:0]                 slot_in_range;
  logic [COMMIT_W-1:0]                 slot_done;
  logic [COMMIT_W-1:0]                 slot_mispred;
  logic [COMMIT_CNT_W-1:0]             commit_cnt;
  logic                                disp_fire;

  assign disp_ready   = (count != CNT_W'(DEPTH));
  assign disp_fire    = disp_valid && disp_ready;
  assign empty        = (count == '0);
  assign disp_rob_idx = tail;

  // Per-slot view of the oldest COMMIT_W entries
  always_comb begin
    slot_idx      = '0;
    slot_in_range = '0;
    slot_done     = '0;
    slot_mispred  = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      slot_idx[k]      = head + ROB_IDX_W'(k);
      slot_in_range[k] = CNT_W'(k) < count;
      slot_done[k]     = entries[slot_idx[k]].base.valid && entries[slot_idx[k]].base.done;
      slot_mispred[k]  = entries[slot_idx[k]].mispred;
    end
  end

  rob_commit_sel #(
    .COMMIT_W (COMMIT_W)
  ) u_commit_sel (
    .stall        (commit_stall),
    .in_range     (slot_in_range),
    .done         (slot_done),
    .mispred      (slot_mispred),
    .commit_valid (commit_valid),
    .commit_cnt   (commit_cnt)
  );

  always_comb begin
    commit_pc         = '0;
    commit_logical_rd = '0;
    commit_phys_rd    = '0;
    commit_result     = '0;
    commit_is_store   = '0;
    commit_is_load    = '0;
    flush             = 1'b0;
    redirect_pc       = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      commit_pc[k]         = entries[slot_idx[k]].base.pc;
      commit_logical_rd[k] = entries[slot_idx[k]].base.logical_rd;
      commit_phys_rd[k]    = entries[slot_idx[k]].base.phys_rd;
      commit_result[k]     = entries[slot_idx[k]].base.result;
      commit_is_store[k]   = entries[slot_idx[k]].base.is_store;
      commit_is_load[k]    = entries[slot_idx[k]].base.is_load;
      if (commit_valid[k] && slot_mispred[k]) begin
        flush       = 1'b1;
        redirect_pc = entries[slot_idx[k]].actual_target;
      end
    end
  end

  always_comb begin
    disp_entry                  = '0;
    disp_entry.base.valid       = 1'b1;
    disp_entry.base.pc          = disp_pc;
    disp_entry.base.logical_rd  = disp_logical_rd;
    disp_entry.base.phys_rd     = disp_phys_rd;
    disp_entry.base.is_store    = disp_is_store;
    disp_entry.base.is_load     = disp_is_load;
    disp_entry.base.is_branch   = disp_is_branch;
    disp_entry.base.pred_taken  = disp_pred_taken;
    disp_entry.base.pred_target = disp_pred_target;
  end

  // Later ports in the loop override earlier ones on an index collision
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].base.valid <= 1'b0;
        entries[i].base.done  <= 1'b0;
        entries[i].mispred    <= 1'b0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].base.valid <= 1'b0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid[p] && entries[wb_rob_idx[p]].base.valid) begin
          entries[wb_rob_idx[p]].base.done   <= 1'b1;
          entries[wb_rob_idx[p]].base.result <= wb_result[p];
          if (entries[wb_rob_idx[p]].base.is_branch) begin
            entries[wb_rob_idx[p]].mispred <= branch_mispred(
              entries[wb_rob_idx[p]].base.pred_taken, entries[wb_rob_idx[p]].base.pred_target,
              wb_actual_taken[p], wb_actual_target[p]);
            entries[wb_rob_idx[p]].actual_target <= wb_actual_taken[p] ? wb_actual_target[p]
              : INSTR_MEM_IDX_W'(entries[wb_rob_idx[p]].base.pc + 1'b1);
          end
        end
      end
      for (int k = 0; k < COMMIT_W; k++) begin
        if (commit_valid[k]) begin
          entries[slot_idx[k]].base.valid <= 1'b0;
        end
      end
      if (disp_fire) begin
        entries[tail] <= disp_entry;
      end
      head  <= head + ROB_IDX_W'(commit_cnt);
      tail  <= tail + ROB_IDX_W'(disp_fire);
      count <= count + CNT_W'(disp_fire) - CNT_W'(commit_cnt);
    end
  end

`ifdef ROB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_commits     <= '0;
      perf_flushes     <= '0;
      perf_full_cycles <= '0;
    end else begin
      perf_commits <= perf_commits + 32'(commit_cnt);
      if (flush) begin
        perf_flushes <= perf_flushes + 32'd1;
      end
      if (disp_valid && !disp_ready) begin
        perf_full_cycles <= perf_full_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/rob_nw.md
Name: rob_nw

Overview:
- Parametrised in-order-commit reorder buffer; successor to the single-entry-access ROB.
- Owns head, tail and occupancy internally, and accepts 1 dispatch per cycle.
- Accepts WB_PORTS execution writebacks per cycle and retires up to COMMIT_W done entries per cycle.
- Detects branch mispredicts at writeback and raises flush/redirect when the branch commits.
- Sits between rename/dispatch and the architectural commit/free-list logic.

Parameters:
- DEPTH, ROB_LENGTH: entry count; power of two, at least 4.
- COMMIT_W, 2: maximum entries retired per cycle; range 1..4.
- WB_PORTS, 2: number of execution writeback channels.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  ROB not full.
- disp_pc  in  INSTR_MEM_IDX_W  instruction index.
- disp_logical_rd  in  ARCH_REG_IDX_W  architectural destination.
- disp_phys_rd  in  PHYS_REG_IDX_W  physical destination.
- disp_is_store, disp_is_load, disp_is_branch  in  1 each  instruction class.
- disp_pred_taken  in  1  predicted direction.
- disp_pred_target  in  INSTR_MEM_IDX_W  predicted target.
- disp_rob_idx  out  ROB_IDX_W  index the dispatched entry receives (equals tail).
- wb_valid  in  WB_PORTS  per-port writeback strobe.
- wb_rob_idx  in  WB_PORTS x ROB_IDX_W  target entry.
- wb_result  in  WB_PORTS x INT_DATA_W  result.
- wb_actual_taken  in  WB_PORTS  resolved direction.
- wb_actual_target  in  WB_PORTS x INSTR_MEM_IDX_W  resolved target.
- commit_stall  in  1  downstream cannot retire this cycle.
- commit_valid  out  COMMIT_W  slot k retires; asserted bits are contiguous from bit 0.
- commit_pc, commit_logical_rd, commit_phys_rd, commit_result, commit_is_store, commit_is_load  out  COMMIT_W x field  per-slot retire data.
- flush  out  1  mispredict redirect.
- redirect_pc  out  INSTR_MEM_IDX_W  fetch restart index.
- empty  out  1  occupancy is 0.

Behaviour:
- Occupancy state: head, tail (ROB_IDX_W bits, natural wrap) and count (ROB_IDX_W+1 bits).
- Reset:
  - All entry valid/done/mispred bits, head, tail and count are cleared.
  - Resulting outputs: disp_ready=1, empty=1, commit_valid=0, flush=0, redirect_pc=0, disp_rob_idx=0.
- Dispatch:
  - disp_ready = (count != DEPTH), computed from registered count only.
  - On disp_valid && disp_ready, the entry at tail is written (valid=1, done=0, mispred=0) and tail increments.
  - disp_valid while not ready is ignored.
- Writeback:
  - For each port with wb_valid set and a valid target entry, the entry gets done=1 and result.
  - If the entry is a branch, it also stores actual_target and mispred = (actual_taken != pred_taken) || (actual_taken && actual_target != pred_target).
  - Writeback to an invalid entry is ignored.
  - If two ports hit the same index, the higher port number wins.
  - Writeback updates become visible to commit one cycle later; there is no same-cycle bypass.
- Commit (combinational from registered state):
  - Slot k is valid iff !commit_stall, k < count, entry head+k has done=1, all slots below k are valid, and no slot below k holds a mispredicted branch.
  - Retired entries get valid cleared; head advances by the number of asserted slots, wrapping modulo DEPTH.
- Count update: count_next = count + dispatched - committed. A dispatch at full is refused even if a commit occurs in the same cycle.
- Flush:
  - flush=1 in the cycle a committing slot holds mispred=1; it is never asserted while commit_stall=1.
  - redirect_pc = actual_target if actual_taken, else pc+1 (word index); otherwise redirect_pc=0.
  - The mispredicted branch itself retires; all younger entries are squashed.
  - Next cycle: head=tail=count=0 and all valid bits are cleared.
  - Dispatch and writebacks presented in the flush cycle are dropped.
- rst asserted mid-operation overrides everything, including flush.

Optional Feature:
- ROB_PERF_CNT_EN defined:
  - Adds 32-bit outputs perf_commits (sum of retired slots, wraps), perf_flushes (number of flush cycles) and perf_full_cycles (cycles with disp_valid && !disp_ready).
  - All three are cleared by rst.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Add to general_defines:
  - rob_nw_entry_t, extending rob_entry_t with mispred and actual_target.
  - ROB_COMMIT_W_MAX = 4.
  - Function branch_mispred(pred_taken, pred_target, act_taken, act_target).
- Sub-module rob_commit_sel: combinational prefix selection of commit slots from the per-slot done/mispred/in-range vectors; outputs commit_valid and the commit count.

Test Plan (DEPTH=8, COMMIT_W=2, WB_PORTS=2):
- Reset, then 8 dispatches at pc 0..7 -> disp_rob_idx 0..7; disp_ready=0 after the 8th; a 9th disp_valid is ignored and tail stays 0.
- Writeback idx 1 then idx 0 (result 0x11, 0x10) -> no commit while only idx 1 is done; the cycle after idx 0 is done, both slots retire with results 0x10, 0x11 and head=2.
- Both ports write idx 3 in the same cycle (0xAA on port 0, 0xBB on port 1) -> commit_result=0xBB when idx 3 retires.
- Branch at idx 0, pred_taken=0, resolved taken to target 0x40; younger idx 1 is done -> commit_valid=01, flush=1, redirect_pc=0x40; next cycle empty=1 and disp_rob_idx=0.
- Not-taken branch predicted taken at pc 0x20 -> flush with redirect_pc=0x21.
- Full ROB with head done and disp_valid held -> one commit, dispatch refused that cycle, accepted the next; count stays at 8 → 7 → 8.
